comm_rspns_buffer: RTL and testbench

//   Packet FIFO between comm_process.v (writer) and comm_transmitter (reader).

---
 rtl/comm_rspns_buffer_pkg.sv | 19 +
 rtl/comm_rspns_buffer_if.sv | 26 ++
 rtl/comm_rspns_buffer_sync_fifo.sv | 53 +++++
 rtl/comm_rspns_buffer.sv | 103 ++++++++++
 tb/tb_comm_rspns_buffer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/comm_rspns_buffer_pkg.sv
// Shared definitions for the response packet buffer: word width, FSM states
// and the stored FIFO entry layout {last, data}.
package comm_rspns_buffer_pkg;

  localparam int unsigned COMM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                   last;
    logic [COMM_WORD_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/comm_rspns_buffer_if.sv
// Handshake bundle between the response buffer, its writer and the transmitter.
//   master: writer/transmitter side (drives wr_*, rspns_read, tx_machine_on)
//   slave : buffer side (drives wr_full, transmitter_on, rspns)
interface comm_rspns_buffer_if;
  import comm_rspns_buffer_pkg::*;

  logic                   wr_en;
  logic [COMM_WORD_W-1:0] wr_data;
  logic                   wr_last;
  logic                   wr_full;
  logic                   transmitter_on;
  logic [COMM_WORD_W-1:0] rspns;
  logic                   rspns_read;
  logic                   tx_machine_on;

  modport master (
    output wr_en, wr_data, wr_last, rspns_read, tx_machine_on,
    input  wr_full, transmitter_on, rspns
  );

  modport slave (
    input  wr_en, wr_data, wr_last, rspns_read, tx_machine_on,
    output wr_full, transmitter_on, rspns
  );

endinterface

// File: rtl/comm_rspns_buffer_sync_fifo.sv
// Single-clock FIFO, 2**DEPTH_LOG2 entries of WIDTH bits.
// push/pop must already be qualified by the caller (no internal full/empty guard).
//   clk, rst       : clock, asynchronous active-high reset
//   push, wr_data  : write an entry
//   pop            : discard the head entry
//   head           : current head entry (combinational)
//   full, empty    : occupancy flags
module comm_sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned WIDTH      = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == {1'b1, {DEPTH_LOG2{1'b0}}});
  assign empty = (count == '0);

endmodule

// File: rtl/comm_rspns_buffer.sv
// Packet FIFO between the response writer and the transmitter. A packet is
// offered (transmitter_on) only once its last word is stored, so the
// transmitter never underruns.
//   inclk, rst   : clock, asynchronous active-high reset
//   bus (slave)  : wr_en/wr_data/wr_last/wr_full, transmitter_on/rspns/rspns_read,
//                  tx_machine_on
//   pkt_pending  : at least one complete packet stored
//   ovf_err      : sticky, a write was dropped
//   len_err      : sticky, FIFO full with no complete packet
module comm_rspns_buffer
  import comm_rspns_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                inclk,
  input  logic                rst,
  comm_rspns_buffer_if.slave  bus,
  output logic                pkt_pending,
  output logic                ovf_err,
  output logic                len_err
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

  state_t                 state_q, state_d;
  entry_t                 head, wr_entry;
  logic                   push, pop, pop_last;
  logic                   full, empty;
  logic [DEPTH_LOG2:0]    pkt_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   gap_load, gap_done;
  logic [COMM_WORD_W-1:0] rspns_q;

  // A write while full is still taken when the head is popped on the same
  // edge: the freed slot is the one being written, so count stays at full.
  assign pop      = bus.rspns_read && (state_q == SEND) && !empty;
  assign push     = bus.wr_en && (!full || pop);
  assign pop_last = pop && head.last;
  assign wr_entry = '{last: bus.wr_last, data: bus.wr_data};

  comm_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      ($bits(entry_t))
  ) u_fifo (
    .clk     (inclk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_cnt <= '0;
      gap_cnt <= '0;
      rspns_q <= '0;
      ovf_err <= 1'b0;
      len_err <= 1'b0;
    end else begin
      state_q <= state_d;
      rspns_q <= head.data;
      unique case ({push && bus.wr_last, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (gap_load)                       gap_cnt <= GAP_W'(GAP_CYCLES - 1);
      else if (state_q == GAP && !gap_done) gap_cnt <= gap_cnt - 1'b1;
      if (bus.wr_en && !push)      ovf_err <= 1'b1;
      if (full && pkt_cnt == '0)   len_err <= 1'b1;
    end
  end

  assign gap_done = (gap_cnt == '0);

  always_comb begin
    state_d  = state_q;
    gap_load = 1'b0;
    unique case (state_q)
      IDLE:  if (pkt_cnt != '0 && !bus.tx_machine_on) state_d = SEND;
      SEND:  if (pop_last) state_d = DRAIN;
      DRAIN: if (!bus.tx_machine_on) begin
               state_d  = GAP;
               gap_load = 1'b1;
             end
      GAP:   if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded from the state register so it falls on the popping edge and
  // drops immediately on reset.
  assign bus.transmitter_on = (state_q == SEND);
  assign bus.rspns          = rspns_q;
  assign bus.wr_full        = full;
  assign pkt_pending        = (pkt_cnt != '0);

endmodule

// File: tb/tb_comm_rspns_buffer.sv
// Directed bench for comm_rspns_buffer (DEPTH_LOG2=5, GAP_CYCLES=4).
module tb_comm_rspns_buffer;

  logic inclk;
  logic rst;
  logic pkt_pending, ovf_err, len_err;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  comm_rspns_buffer_if bus ();

  comm_rspns_buffer #(
    .DEPTH_LOG2 (5),
    .GAP_CYCLES (4)
  ) dut (
    .inclk       (inclk),
    .rst         (rst),
    .bus         (bus),
    .pkt_pending (pkt_pending),
    .ovf_err     (ovf_err),
    .len_err     (len_err)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] data, input logic last);
    bus.wr_en   = 1'b1;
    bus.wr_data = data;
    bus.wr_last = last;
    tick();
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
  endtask

  task automatic rd();
    bus.rspns_read = 1'b1;
    tick();
    bus.rspns_read = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst               = 1'b1;
    bus.wr_en         = 1'b0;
    bus.wr_data       = '0;
    bus.wr_last       = 1'b0;
    bus.rspns_read    = 1'b0;
    bus.tx_machine_on = 1'b0;
    tick();
    tick();
    check("rst_on",      bus.transmitter_on, 0);
    check("rst_full",    bus.wr_full,        0);
    check("rst_rspns",   bus.rspns,          0);
    check("rst_pending", pkt_pending,        0);
    check("rst_ovf",     ovf_err,            0);
    check("rst_len",     len_err,            0);
    rst = 1'b0;
    tick();

    // 3-word packet; offered only after the last word
    wr(32'hA1, 1'b0);
    wr(32'hA2, 1'b0);
    wr(32'hA3, 1'b1);
    check("t1_on_before", bus.transmitter_on, 0);
    check("t1_pending",   pkt_pending,        1);
    tick();
    check("t1_on_rise",   bus.transmitter_on, 1);
    check("t1_rspns_a1",  bus.rspns,          32'hA1);
    bus.tx_machine_on = 1'b1;
    rd();
    tick();
    check("t1_rspns_a2",  bus.rspns,          32'hA2);
    check("t1_on_mid",    bus.transmitter_on, 1);
    rd();
    tick();
    check("t1_rspns_a3",  bus.rspns,          32'hA3);
    rd();
    check("t1_on_fall",   bus.transmitter_on, 0);
    check("t1_pend_clr",  pkt_pending,        0);

    // Back-to-back packet waits for stop byte plus gap
    tick();
    tick();
    check("t3_drain_low", bus.transmitter_on, 0);
    wr(32'hB1, 1'b1);
    check("t3_drain_hold", bus.transmitter_on, 0);
    bus.tx_machine_on = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t3_gap_low", bus.transmitter_on, 0);
    end
    tick();
    check("t3_rise",     bus.transmitter_on, 1);
    check("t3_rspns_b1", bus.rspns,          32'hB1);
    bus.tx_machine_on = 1'b1;
    rd();
    check("t3_fall",     bus.transmitter_on, 0);
    bus.tx_machine_on = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Over-long packet: fill without last, then one more
    do_reset();
    for (int i = 0; i < 32; i++) wr(32'h200 + i, 1'b0);
    check("t4_full",      bus.wr_full,        1);
    check("t4_len_pre",   len_err,            0);
    check("t4_ovf_pre",   ovf_err,            0);
    wr(32'h2FF, 1'b0);
    check("t4_full2",     bus.wr_full,        1);
    check("t4_ovf",       ovf_err,            1);
    check("t4_len",       len_err,            1);
    tick();
    check("t4_on",        bus.transmitter_on, 0);

    // Write and pop together while full
    do_reset();
    bus.tx_machine_on = 1'b1;
    for (int i = 0; i < 32; i++) wr(32'h100 + i, (i == 31));
    check("t5_full",      bus.wr_full,        1);
    check("t5_pending",   pkt_pending,        1);
    check("t5_len_none",  len_err,            0);
    check("t5_on_held",   bus.transmitter_on, 0);
    bus.tx_machine_on = 1'b0;
    tick();
    check("t5_on",        bus.transmitter_on, 1);
    check("t5_rspns0",    bus.rspns,          32'h100);
    bus.wr_en      = 1'b1;
    bus.wr_data    = 32'hC0;
    bus.wr_last    = 1'b1;
    bus.rspns_read = 1'b1;
    tick();
    bus.wr_en      = 1'b0;
    bus.wr_last    = 1'b0;
    bus.rspns_read = 1'b0;
    check("t5_full_kept", bus.wr_full,        1);
    check("t5_ovf",       ovf_err,            0);
    check("t5_len",       len_err,            0);
    check("t5_on_kept",   bus.transmitter_on, 1);
    tick();
    check("t5_rspns1",    bus.rspns,          32'h101);

    // Reset in the middle of a packet
    do_reset();
    wr(32'hD1, 1'b0);
    wr(32'hD2, 1'b0);
    wr(32'hD3, 1'b1);
    tick();
    check("t6_on",        bus.transmitter_on, 1);
    bus.tx_machine_on = 1'b1;
    rd();
    check("t6_on_mid",    bus.transmitter_on, 1);
    rst = 1'b1;
    #1;
    check("t6_on_async",  bus.transmitter_on, 0);
    check("t6_pending",   pkt_pending,        0);
    check("t6_full",      bus.wr_full,        0);
    check("t6_rspns",     bus.rspns,          0);
    tick();
    rst = 1'b0;
    bus.tx_machine_on = 1'b0;
    rd();
    wr(32'hE1, 1'b1);
    tick();
    check("t6_next_on",    bus.transmitter_on, 1);
    check("t6_next_rspns", bus.rspns,          32'hE1);
    bus.tx_machine_on = 1'b1;
    rd();
    check("t6_next_fall",  bus.transmitter_on, 0);
    check("t6_next_pend",  pkt_pending,        0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
